// File: rtl/shift_delay_timer.sv
// Serially loaded 4-bit delay timer: counts (delay+1) units of CYCLES_PER_UNIT
// clocks, then holds done until acknowledged.
module shift_delay_timer #(
  parameter int CYCLES_PER_UNIT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shift_ena,
  input  logic       data,
  input  logic       start,
  input  logic       ack,
  output logic [3:0] count,
  output logic       counting,
  output logic       done
);

  localparam int UW = $clog2(CYCLES_PER_UNIT);
  localparam logic [UW-1:0] UNIT_RELOAD = UW'(CYCLES_PER_UNIT - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      delay_q, delay_d;
  logic [3:0]      count_q, count_d;
  logic [UW-1:0]   unit_q,  unit_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COUNT;
      COUNT:   if ((unit_q == '0) && (count_q == 4'd0)) state_d = DONE;
      DONE:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Count captures the delay as it was before this edge's shift.
  always_comb begin
    delay_d = delay_q;
    count_d = count_q;
    unit_d  = unit_q;
    unique case (state_q)
      IDLE: begin
        if (shift_ena) delay_d = {delay_q[2:0], data};
        if (start) begin
          count_d = delay_q;
          unit_d  = UNIT_RELOAD;
        end
      end
      COUNT: begin
        if (unit_q != '0) begin
          unit_d = unit_q - UW'(1);
        end else if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
          unit_d  = UNIT_RELOAD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_q <= 4'd0;
      count_q <= 4'd0;
      unit_q  <= '0;
    end else begin
      delay_q <= delay_d;
      count_q <= count_d;
      unit_q  <= unit_d;
    end
  end

  always_comb begin
    counting = (state_q == COUNT);
    done     = (state_q == DONE);
    count    = counting ? count_q : 4'd0;
  end

endmodule

// File: tb/tb_shift_delay_timer.sv
// Directed bench for shift_delay_timer: a CYCLES_PER_UNIT=4 instance for the
// functional cases and a default-parameter instance for the long-delay case.
module tb_shift_delay_timer;

  logic       clk = 1'b0;
  logic       reset, shift_ena, data, start, ack;
  logic [3:0] count_s, count_b;
  logic       counting_s, counting_b, done_s, done_b;

  int n_checks = 0;
  int n_errors = 0;

  shift_delay_timer #(.CYCLES_PER_UNIT(4)) dut (
    .clk(clk), .reset(reset), .shift_ena(shift_ena), .data(data),
    .start(start), .ack(ack), .count(count_s), .counting(counting_s), .done(done_s)
  );

  shift_delay_timer dut_big (
    .clk(clk), .reset(reset), .shift_ena(shift_ena), .data(data),
    .start(start), .ack(ack), .count(count_b), .counting(counting_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift4(input logic [3:0] v);
    shift_ena = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      data = v[i];
      tick();
    end
    shift_ena = 1'b0;
    data      = 1'b0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts consecutive counting cycles starting at the current sample and
  // tallies samples whose count differs from first_cnt - len/cpu.
  task automatic measure(input bit big, input int first_cnt, input int cpu,
                         input int budget, input bit disturb,
                         output int len, output int bad);
    logic [3:0] exp_cnt;
    len = 0;
    bad = 0;
    while (((big ? counting_b : counting_s) === 1'b1) && (len < budget)) begin
      exp_cnt = 4'(first_cnt - len / cpu);
      if ((big ? count_b : count_s) !== exp_cnt) bad++;
      if (disturb) begin
        shift_ena = len[0];
        data      = len[1];
        start     = len[2];
      end
      len++;
      tick();
    end
    shift_ena = 1'b0;
    data      = 1'b0;
    start     = 1'b0;
  endtask

  int len, bad, hits;

  initial begin
    reset = 1'b1; shift_ena = 1'b0; data = 1'b0; start = 1'b0; ack = 1'b0;
    #1;
    check_eq("rst_count", count_s, 0);
    check_eq("rst_counting", counting_s, 0);
    check_eq("rst_done", done_s, 0);
    tick();
    reset = 1'b0;

    // Load 1010 then run a 44-cycle count
    shift4(4'b1010);
    start_pulse();
    check_eq("t1_entry_count", count_s, 10);
    check_eq("t1_entry_counting", counting_s, 1);
    measure(1'b0, 10, 4, 200, 1'b0, len, bad);
    check_eq("t1_len", len, 44);
    check_eq("t1_steps", bad, 0);
    check_eq("t1_done", done_s, 1);
    check_eq("t1_done_count", count_s, 0);
    ack_pulse();
    check_eq("t1_ack_done", done_s, 0);

    // Zero delay: four counting cycles, done held until ack
    shift4(4'b0000);
    start_pulse();
    check_eq("t2_entry_count", count_s, 0);
    measure(1'b0, 0, 4, 100, 1'b0, len, bad);
    check_eq("t2_len", len, 4);
    check_eq("t2_steps", bad, 0);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_s !== 1'b1) hits++;
      tick();
    end
    check_eq("t2_done_hold", hits, 0);
    ack_pulse();
    check_eq("t2_ack_done", done_s, 0);
    check_eq("t2_ack_counting", counting_s, 0);

    // ack on the DONE-entry edge must not be consumed
    start_pulse();
    tick(); tick(); tick();
    check_eq("t2b_still_counting", counting_s, 1);
    ack = 1'b1;
    tick();
    check_eq("t2b_entry_ack_kept", done_s, 1);
    tick();
    ack = 1'b0;
    check_eq("t2b_second_ack", done_s, 0);

    // Input activity during COUNT/DONE leaves delay and timing untouched
    shift4(4'b0101);
    start_pulse();
    check_eq("t3_entry_count", count_s, 5);
    measure(1'b0, 5, 4, 200, 1'b1, len, bad);
    check_eq("t3_len", len, 24);
    check_eq("t3_steps", bad, 0);
    start_pulse();
    check_eq("t3_start_in_done", done_s, 1);
    ack_pulse();
    start_pulse();
    check_eq("t3_delay_kept", count_s, 5);
    measure(1'b0, 5, 4, 200, 1'b0, len, bad);
    check_eq("t3_len2", len, 24);
    ack_pulse();

    // Asynchronous reset mid-count
    start_pulse();
    for (int i = 0; i < 5; i++) tick();
    #3;
    reset = 1'b1;
    #1;
    check_eq("t4_async_counting", counting_s, 0);
    check_eq("t4_async_count", count_s, 0);
    check_eq("t4_async_done", done_s, 0);
    #1;
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_s !== 1'b0 || counting_s !== 1'b0) hits++;
      tick();
    end
    check_eq("t4_no_done", hits, 0);
    start_pulse();
    check_eq("t4_idle_after_rst", counting_s, 1);
    measure(1'b0, 0, 4, 100, 1'b0, len, bad);
    check_eq("t4_len_delay0", len, 4);
    ack_pulse();

    // Shift and start on the same edge
    shift4(4'b0011);
    shift_ena = 1'b1; data = 1'b1; start = 1'b1;
    tick();
    shift_ena = 1'b0; data = 1'b0; start = 1'b0;
    check_eq("t5_pre_shift_count", count_s, 3);
    measure(1'b0, 3, 4, 200, 1'b0, len, bad);
    check_eq("t5_len3", len, 16);
    check_eq("t5_steps", bad, 0);
    ack_pulse();
    start_pulse();
    check_eq("t5_new_delay", count_s, 7);
    measure(1'b0, 7, 4, 200, 1'b0, len, bad);
    check_eq("t5_len7", len, 32);
    ack_pulse();

    // Default parameter, delay 15
    reset = 1'b1;
    tick();
    reset = 1'b0;
    shift4(4'b1111);
    start_pulse();
    check_eq("t6_entry_count", count_b, 15);
    measure(1'b1, 15, 1000, 17000, 1'b0, len, bad);
    check_eq("t6_len", len, 16000);
    check_eq("t6_steps", bad, 0);
    check_eq("t6_done", done_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_delay_timer.md
SHIFT_DELAY_TIMER -- requirements
Module: shift_delay_timer

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_UNIT, default 1000, meaning clock cycles per unit of programmed delay; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port shift_ena, input, 1 bit: from the upstream shift-enable FSM; while high, data is shifted into the delay register.
REQ-005 The block SHALL have port data, input, 1 bit: serial delay value, MSB first.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin the timed count.
REQ-007 The block SHALL have port ack, input, 1 bit: acknowledges done.
REQ-008 The block SHALL have port count, output, 4 bits: remaining whole units while counting; 0 otherwise.
REQ-009 The block SHALL have port counting, output, 1 bit: high while in COUNT.
REQ-010 The block SHALL have port done, output, 1 bit: high while in DONE.

Function
REQ-011 The block SHALL implement three states: IDLE, COUNT, DONE.
REQ-012 In IDLE, each edge with shift_ena=1 SHALL perform delay <= {delay[2:0], data}; with shift_ena=0, delay SHALL hold.
REQ-013 shift_ena SHALL be ignored in COUNT and DONE; delay SHALL hold.
REQ-014 An IDLE edge with start=1 SHALL enter COUNT and load count <= delay and the unit counter <= CYCLES_PER_UNIT-1.
REQ-015 When shift_ena=1 and start=1 on the same IDLE edge, the shift SHALL occur, and count SHALL load the pre-shift delay value.
REQ-016 In COUNT, each edge SHALL decrement the unit counter when it is nonzero.
REQ-017 In COUNT, when the unit counter is 0 and count>0, the block SHALL decrement count and reload the unit counter to CYCLES_PER_UNIT-1.
REQ-018 In COUNT, when the unit counter is 0 and count=0, the block SHALL enter DONE.
REQ-019 counting SHALL be high for exactly (delay+1)*CYCLES_PER_UNIT consecutive cycles per start.
REQ-020 start SHALL be ignored in COUNT and DONE, and ack SHALL be ignored in IDLE and COUNT.
REQ-021 In DONE, done SHALL be held until an edge with ack=1, which SHALL return the block to IDLE; ack present on the DONE-entry edge SHALL NOT be consumed.
REQ-022 count SHALL read 0 in IDLE and DONE.
REQ-023 The unit counter SHALL be $clog2(CYCLES_PER_UNIT) bits wide and SHALL never wrap below 0.
REQ-024 All outputs SHALL be registered or decoded directly from state, with no combinational input-to-output paths.

Reset
REQ-025 Reset assertion SHALL immediately, without waiting for clk, force state=IDLE, delay=0, count=0, unit counter=0, counting=0, done=0.
REQ-026 Reset asserted mid-COUNT or in DONE SHALL abort the operation with no done pulse.
REQ-027 After reset deasserts, the first active edge SHALL behave as IDLE.

Verification (CYCLES_PER_UNIT=4 unless stated)
REQ-028 Reset, shift_ena high for 4 cycles with data 1,0,1,0, then start pulse -> count=10 on the entry edge; counting high 44 cycles; count steps 10..0 every 4 cycles; done rises next edge.
REQ-029 delay=0, start -> counting high exactly 4 cycles, count=0 throughout, then done=1 held for 20 cycles with ack=0; ack pulse -> IDLE next edge, done=0.
REQ-030 During COUNT, toggle shift_ena/data and pulse start -> delay and count unaffected, total count length unchanged.
REQ-031 Assert reset asynchronously mid-COUNT (between edges) -> counting=0 and count=0 before the next clk edge; no done.
REQ-032 shift_ena=1 and start=1 on the same IDLE edge with delay=3, data=1 -> count loads 3, delay becomes 7; next run with delay 7 -> 32 counting cycles.
REQ-033 Default CYCLES_PER_UNIT=1000, delay=15 -> counting high exactly 16000 cycles.
